dmem_access_unit: RTL and testbench
===================================

# dmem_access_unit

Memory-stage data access sequencer for the pipelined MIPS core. It sits between the EX/MEM latch and the datapath-side cache port, and services LW, SW, LL and SC. It produces the `dhit` completion strobe consumed by the hazard unit's MEM-stall logic, and owns the LL/SC link register with snoop-invalidation. Non-memory instructions pass through untouched.

## Interface
- Parameters: none. All data and address paths are 32 bits.
- `CLK` in 1: core clock; all state updates on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `opcode` in 6: EX/MEM opcode. LW=6'h23, SW=6'h2B, LL=6'h30, SC=6'h38.
- `addr` in 32: EX/MEM effective address, word aligned.
- `store_data` in 32: EX/MEM store operand.
- `flushed` in 1: hazard unit's branch/jump flush indication.
- `cache_hit` in 1: cache reports that the current request completed.
- `dmemload` in 32: cache read data, valid with `cache_hit`.
- `ccinv` in 1: coherence invalidate strobe.
- `ccsnoopaddr` in 32: address being invalidated.
- `dmemREN` out 1: read request to the cache.
- `dmemWEN` out 1: write request to the cache.
- `dmemaddr` out 32: request address.
- `dmemstore` out 32: request write data.
- `dhit` out 1: one-cycle completion pulse to the hazard unit.
- `load_data` out 32: result to MEM/WB. Holds load data, or the SC result 1/0.
- `link_valid` out 1: link register valid, for debug and coverage.

## Operation
- Registered state: `state` (IDLE, ACCESS, DONE), `link_reg[31:0]`, `link_valid`, `result[31:0]`. `load_data` = `result`.
- IDLE
  - All request outputs are 0 and `dhit`=0.
  - A memory opcode with `flushed`=0 is a request. Any other opcode, or `flushed`=1, stays in IDLE.
  - SC with (`link_valid`=0 or `link_reg`≠`addr`): `result`←0, go to DONE. No cache request is issued.
  - Any other request: go to ACCESS.
- ACCESS
  - `dmemaddr`=`addr` and `dmemstore`=`store_data`.
  - `dmemREN`=1 for LW and LL. `dmemWEN`=1 for SW and SC.
  - `flushed` is ignored; the transaction runs to completion.
  - On `cache_hit`, go to DONE and commit:
    - LW: `result`←`dmemload`.
    - LL: `result`←`dmemload`, `link_reg`←`addr`, `link_valid`←1.
    - SW: if `link_reg`==`addr`, `link_valid`←0.
    - SC: `result`←1, `link_valid`←0.
  - SC abort: if, while waiting without `cache_hit`, an invalidate matches the link (see below), drop `dmemWEN` that cycle, set `result`←0, go to DONE. The cache tolerates WEN withdrawal before hit.
- DONE: `dhit`=1 and all requests are 0. Go to IDLE unconditionally; the pipeline advances at this edge.
- Link invalidation: when `ccinv`=1 and `ccsnoopaddr`==`link_reg`, `link_valid`←0 in any state.
- Simultaneous events:
  - An LL commit and a matching invalidate in the same cycle: the LL commit wins, and `link_valid` ends at 1.
  - An SC `cache_hit` and a matching invalidate in the same cycle: the SC succeeds, because the write is already performed.
- Reset (synchronous, `RST`=1): `state`=IDLE, `link_reg`=0, `link_valid`=0, `result`=0. All outputs are 0 in the following cycle. Reset during ACCESS drops the request immediately.

## Timing
- Request outputs are combinational from `state` and the EX/MEM inputs. `dhit` is a Moore output of DONE.
- A hit on the first ACCESS cycle gives this sequence:
  - cycle 0: IDLE.
  - cycle 1: ACCESS, with `cache_hit`.
  - cycle 2: DONE, with `dhit`.
  - Minimum latency from request to `dhit` is 2 cycles.
- A miss adds one cycle per ACCESS cycle without `cache_hit`.
- A failed SC skips ACCESS: `dhit` is asserted 1 cycle after detection.
- `dhit` is never high for 2 consecutive cycles.
- `load_data` is stable from DONE until the next commit.

## Test plan
- Reset: hold `RST` 2 cycles during an ACCESS. Required next cycle: state IDLE; `dmemREN`=`dmemWEN`=`dhit`=`link_valid`=0; `load_data`=0.
- LW, 3-cycle miss:
  - Stimulus: opcode 6'h23, `addr` 0x100, `cache_hit` on the 3rd ACCESS cycle, `dmemload` 0xDEADBEEF.
  - Required: REN high for 3 cycles, then `dhit` 1 cycle, `load_data`=0xDEADBEEF.
- LL then SC, both hit: LL 0x200, then SC 0x200 with `store_data` 0x5.
  - Required: WEN asserted with `dmemstore`=0x5, `load_data`=1, `link_valid`=0 after.
- LL 0x200, then snoop `ccinv` 0x200, then SC 0x200.
  - Required: no WEN, `dhit` 1 cycle after the request, `load_data`=0.
- SC abort:
  - Stimulus: LL 0x300, then SC 0x300; matching `ccinv` on the 2nd ACCESS cycle with no `cache_hit`.
  - Required: WEN drops that cycle, then DONE with `load_data`=0.
- Flush and pass-through:
  - SW 0x400 with `flushed`=1 in IDLE: no request, no `dhit`.
  - R-type opcode: no request, no `dhit`.
  - LL 0x400, then SW 0x400: `link_valid` cleared on the SW hit.

Source files
------------

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage sequencer for LW/SW/LL/SC.
// Drives the dcache port, pulses dhit, owns the LL/SC link.
module dmem_access_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        flushed,
  input  logic        cache_hit,
  input  logic [31:0] dmemload,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] load_data,
  output logic        link_valid
);

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] OP_LL = 6'h30;
  localparam logic [5:0] OP_SC = 6'h38;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] link_q, link_d;
  logic [31:0] result_q, result_d;
  logic        valid_q, valid_d;

  logic is_lw, is_sw, is_ll, is_sc, is_mem;
  logic link_match, snoop_hit;

  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_ll  = (opcode == OP_LL);
  assign is_sc  = (opcode == OP_SC);
  assign is_mem = is_lw | is_sw | is_ll | is_sc;

  assign link_match = valid_q && (link_q == addr);
  assign snoop_hit  = ccinv && (ccsnoopaddr == link_q);

  always_comb begin
    state_d   = state_q;
    link_d    = link_q;
    valid_d   = valid_q;
    result_d  = result_q;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    dmemaddr  = '0;
    dmemstore = '0;
    dhit      = 1'b0;

    // Commits below override a same-cycle snoop clear.
    if (snoop_hit) valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (is_mem && !flushed) begin
          if (is_sc && !link_match) begin
            result_d = '0;
            state_d  = S_DONE;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        dmemaddr  = addr;
        dmemstore = store_data;
        dmemREN   = is_lw | is_ll;
        dmemWEN   = is_sw | is_sc;
        if (cache_hit) begin
          state_d = S_DONE;
          unique case (1'b1)
            is_lw: result_d = dmemload;
            is_ll: begin
              result_d = dmemload;
              link_d   = addr;
              valid_d  = 1'b1;
            end
            is_sw: begin
              if (link_q == addr) valid_d = 1'b0;
            end
            is_sc: begin
              result_d = 32'd1;
              valid_d  = 1'b0;
            end
            default: ;
          endcase
        end else if (is_sc && snoop_hit) begin
          // Link lost before the write landed: withdraw it.
          dmemWEN  = 1'b0;
          result_d = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        dhit    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (RST) begin
      dmemREN   = 1'b0;
      dmemWEN   = 1'b0;
      dmemaddr  = '0;
      dmemstore = '0;
      dhit      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      link_q   <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      link_q   <= link_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign load_data  = result_q;
  assign link_valid = valid_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed LW/SW/LL/SC scenarios
// against a transaction-level model of the access unit.
module tb_dmem_access_unit;

  localparam logic [5:0] LW = 6'h23;
  localparam logic [5:0] SW = 6'h2B;
  localparam logic [5:0] LL = 6'h30;
  localparam logic [5:0] SC = 6'h38;

  logic        CLK = 1'b0;
  logic        RST;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        flushed;
  logic        cache_hit;
  logic [31:0] dmemload;
  logic        ccinv;
  logic [31:0] ccsnoopaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] load_data;
  logic        link_valid;

  always #5 CLK = ~CLK;

  dmem_access_unit dut (
    .CLK         (CLK),
    .RST         (RST),
    .opcode      (opcode),
    .addr        (addr),
    .store_data  (store_data),
    .flushed     (flushed),
    .cache_hit   (cache_hit),
    .dmemload    (dmemload),
    .ccinv       (ccinv),
    .ccsnoopaddr (ccsnoopaddr),
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN),
    .dmemaddr    (dmemaddr),
    .dmemstore   (dmemstore),
    .dhit        (dhit),
    .load_data   (load_data),
    .link_valid  (link_valid)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_res  = '0;
  logic [31:0] m_link = '0;
  logic        m_lv   = 1'b0;

  logic        e_ren   = 1'b0;
  logic        e_wen   = 1'b0;
  logic        e_dhit  = 1'b0;
  logic [31:0] e_addr  = '0;
  logic [31:0] e_store = '0;
  bit          chk_en  = 1'b0;
  logic        prev_dhit = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("ren", {31'b0, dmemREN}, {31'b0, e_ren});
      check("wen", {31'b0, dmemWEN}, {31'b0, e_wen});
      check("dhit", {31'b0, dhit}, {31'b0, e_dhit});
      check("addr", dmemaddr, e_addr);
      check("store", dmemstore, e_store);
      check("load_data", load_data, m_res);
      check("link_valid", {31'b0, link_valid},
            {31'b0, m_lv});
      check("dhit_pair", {31'b0, dhit & prev_dhit}, 32'd0);
      prev_dhit = dhit;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic exp_idle();
    e_ren   = 1'b0;
    e_wen   = 1'b0;
    e_dhit  = 1'b0;
    e_addr  = '0;
    e_store = '0;
  endtask

  task automatic hold(input logic [5:0] op,
                      input logic [31:0] a,
                      input logic fl,
                      input int n);
    opcode    = op;
    addr      = a;
    flushed   = fl;
    cache_hit = 1'b0;
    ccinv     = 1'b0;
    exp_idle();
    for (int i = 0; i < n; i++) tick();
    flushed = 1'b0;
  endtask

  task automatic snoop(input logic [31:0] a);
    opcode      = 6'h00;
    ccinv       = 1'b1;
    ccsnoopaddr = a;
    exp_idle();
    tick();
    if (a == m_link) m_lv = 1'b0;
    ccinv = 1'b0;
  endtask

  // One memory transaction: nacc ACCESS cycles with the hit on the
  // last one, optional matching snoop on ACCESS cycle snoop_at.
  task automatic txn(input logic [5:0] op,
                     input logic [31:0] a,
                     input logic [31:0] sd,
                     input int nacc,
                     input int snoop_at,
                     input logic [31:0] ld);
    logic fail_sc, snp, abort;
    opcode      = op;
    addr        = a;
    store_data  = sd;
    flushed     = 1'b0;
    cache_hit   = 1'b0;
    ccinv       = 1'b0;
    ccsnoopaddr = a;
    dmemload    = '0;
    exp_idle();
    fail_sc = (op == SC) && !(m_lv && m_link == a);
    tick();
    if (fail_sc) begin
      m_res = '0;
    end else begin
      for (int k = 1; k <= nacc; k++) begin
        e_addr    = a;
        e_store   = sd;
        e_ren     = (op == LW) || (op == LL);
        e_wen     = (op == SW) || (op == SC);
        cache_hit = (k == nacc);
        dmemload  = cache_hit ? ld : 32'h0;
        ccinv     = (k == snoop_at);
        snp       = ccinv && (m_link == a);
        abort     = (op == SC) && snp && !cache_hit;
        if (abort) e_wen = 1'b0;
        tick();
        if (snp) m_lv = 1'b0;
        if (cache_hit) begin
          case (op)
            LW: m_res = ld;
            LL: begin
              m_res  = ld;
              m_link = a;
              m_lv   = 1'b1;
            end
            SW: if (m_link == a) m_lv = 1'b0;
            SC: begin
              m_res = 32'd1;
              m_lv  = 1'b0;
            end
            default: ;
          endcase
        end
        if (abort) m_res = '0;
        if (cache_hit || abort) break;
      end
    end
    cache_hit = 1'b0;
    ccinv     = 1'b0;
    dmemload  = '0;
    exp_idle();
    e_dhit = 1'b1;
    tick();
    e_dhit = 1'b0;
    opcode = 6'h00;
  endtask

  initial begin
    RST         = 1'b1;
    opcode      = 6'h00;
    addr        = '0;
    store_data  = '0;
    flushed     = 1'b0;
    cache_hit   = 1'b0;
    dmemload    = '0;
    ccinv       = 1'b0;
    ccsnoopaddr = '0;
    tick();
    tick();
    RST    = 1'b0;
    chk_en = 1'b1;
    hold(6'h00, 32'h0, 1'b0, 1);

    txn(LW, 32'h100, 32'h0, 3, 0, 32'hDEADBEEF);
    hold(6'h00, 32'h0, 1'b0, 1);
    check("lw_lit", load_data, 32'hDEADBEEF);

    txn(LL, 32'h200, 32'h0, 1, 0, 32'h1234);
    check("ll_lit", {31'b0, link_valid}, 32'd1);
    txn(SC, 32'h200, 32'h5, 1, 0, 32'h0);
    check("sc_ok_lit", load_data, 32'd1);
    check("sc_ok_lv", {31'b0, link_valid}, 32'd0);

    txn(LL, 32'h200, 32'h0, 1, 0, 32'h55);
    snoop(32'h200);
    txn(SC, 32'h200, 32'h5, 1, 0, 32'h0);
    check("sc_fail_lit", load_data, 32'd0);

    txn(LL, 32'h300, 32'h0, 1, 0, 32'hAAAA);
    txn(SC, 32'h300, 32'h7, 3, 2, 32'h0);
    check("sc_abort_lit", load_data, 32'd0);
    check("sc_abort_lv", {31'b0, link_valid}, 32'd0);

    hold(SW, 32'h400, 1'b1, 2);
    hold(6'h00, 32'h400, 1'b0, 2);

    txn(LL, 32'h400, 32'h0, 2, 0, 32'h77);
    check("ll400_lv", {31'b0, link_valid}, 32'd1);
    txn(SW, 32'h400, 32'h9, 1, 0, 32'h0);
    check("sw_clr_lv", {31'b0, link_valid}, 32'd0);

    txn(LL, 32'h400, 32'h0, 1, 1, 32'h88);
    check("ll_snoop_lv", {31'b0, link_valid}, 32'd1);
    txn(SC, 32'h400, 32'h3, 1, 1, 32'h0);
    check("sc_snoop_lit", load_data, 32'd1);

    txn(LL, 32'h500, 32'h0, 1, 0, 32'hCAFE);
    opcode     = LW;
    addr       = 32'h600;
    store_data = 32'h0;
    exp_idle();
    tick();
    e_ren  = 1'b1;
    e_addr = 32'h600;
    tick();
    RST = 1'b1;
    exp_idle();
    tick();
    m_res  = '0;
    m_link = '0;
    m_lv   = 1'b0;
    tick();
    RST    = 1'b0;
    opcode = 6'h00;
    tick();
    check("rst_ld", load_data, 32'd0);
    check("rst_lv", {31'b0, link_valid}, 32'd0);
    check("rst_ren", {31'b0, dmemREN}, 32'd0);
    hold(6'h00, 32'h0, 1'b0, 2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
